// File: rtl/reg_file_bank.sv
// Parametrised register file: two combinational read ports with write bypass, one
// synchronous write port, per-register pending bits and a sequenced array clear.
module reg_file_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] op_one_addr,
  input  logic [ADDR_W-1:0] op_two_addr,
  output logic [DATA_W-1:0] op_one,
  output logic [DATA_W-1:0] op_two,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              pend_one,
  output logic              pend_two,
  input  logic              clr_start,
  output logic              clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  pend_r, pend_nxt_s, pend_clr_mask_s, pend_set_mask_s;
  logic              idle_s, clr_go_s, wr_ok_s, pset_ok_s;

  function automatic logic is_hard_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic bypass_hit(input logic [ADDR_W-1:0] addr, input logic idle,
                                      input logic wen, input logic [ADDR_W-1:0] waddr);
    return idle && wen && (waddr == addr) && !is_hard_zero(addr);
  endfunction

  assign idle_s    = (state_r == IDLE);
  assign clr_go_s  = idle_s && clr_start;
  // The edge that launches a clear swallows that cycle's write and pend_set.
  assign wr_ok_s   = idle_s && !clr_start && wr_en && !is_hard_zero(result_addr);
  assign pset_ok_s = idle_s && !clr_start && pend_set && !is_hard_zero(pend_addr);

  // Clear sequencer next-state and counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (clr_start) begin
          state_nxt_s = CLEAR;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        cnt_nxt_s = cnt_r + 1'b1;
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Clear sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Register array: clear engine has priority over the external write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_r[i] <= '0;
    end else if (state_r == CLEAR) begin
      regs_r[cnt_r] <= '0;
    end else if (wr_ok_s) begin
      regs_r[result_addr] <= din;
    end
  end

  // Set mask applied after clear mask so a new producer wins over a retiring one.
  assign pend_clr_mask_s = wr_ok_s   ? (DEPTH'(1) << result_addr) : '0;
  assign pend_set_mask_s = pset_ok_s ? (DEPTH'(1) << pend_addr)   : '0;
  assign pend_nxt_s      = (pend_r & ~pend_clr_mask_s) | pend_set_mask_s;

  // Pending scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
    end else if (clr_go_s) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Read port 1 with hardwired zero and same-cycle bypass.
  always_comb begin
    if (is_hard_zero(op_one_addr)) begin
      op_one = '0;
    end else if (bypass_hit(op_one_addr, idle_s, wr_en, result_addr)) begin
      op_one = din;
    end else begin
      op_one = regs_r[op_one_addr];
    end
  end

  // Read port 2 with hardwired zero and same-cycle bypass.
  always_comb begin
    if (is_hard_zero(op_two_addr)) begin
      op_two = '0;
    end else if (bypass_hit(op_two_addr, idle_s, wr_en, result_addr)) begin
      op_two = din;
    end else begin
      op_two = regs_r[op_two_addr];
    end
  end

  assign pend_one = pend_r[op_one_addr];
  assign pend_two = pend_r[op_two_addr];
  assign clr_busy = (state_r == CLEAR);

endmodule

// File: tb/tb_reg_file_bank.sv
// Bench for reg_file_bank: one ZERO_REG=1 and one ZERO_REG=0 instance share stimulus;
// an array-level model is compared every negedge, plus directed literal checks.
module tb_reg_file_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  result_addr;
  logic [31:0] din;
  logic [4:0]  op_one_addr, op_two_addr;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic        clr_start;

  logic [31:0] op_one_a, op_two_a, op_one_b, op_two_b;
  logic        pend_one_a, pend_two_a, pend_one_b, pend_two_b;
  logic        busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_bank #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .result_addr(result_addr), .din(din),
    .op_one_addr(op_one_addr), .op_two_addr(op_two_addr), .op_one(op_one_a), .op_two(op_two_a),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_one(pend_one_a), .pend_two(pend_two_a),
    .clr_start(clr_start), .clr_busy(busy_a));

  reg_file_bank #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .wr_en(wr_en), .result_addr(result_addr), .din(din),
    .op_one_addr(op_one_addr), .op_two_addr(op_two_addr), .op_one(op_one_b), .op_two(op_two_b),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_one(pend_one_b), .pend_two(pend_two_b),
    .clr_start(clr_start), .clr_busy(busy_b));

  // Model: index 0 = hardwired-zero instance, index 1 = ordinary register 0.
  logic [31:0] m_regs [2][32];
  logic        m_pend [2][32];
  bit          m_busy = 1'b0;
  int          m_cidx = 0;

  function automatic bit m_zero(int k, logic [4:0] a);
    return (k == 0) && (a == 5'd0);
  endfunction

  function automatic logic [31:0] m_read(int k, logic [4:0] a);
    if (m_zero(k, a)) return 32'd0;
    if (!m_busy && wr_en && result_addr == a) return din;
    return m_regs[k][a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin m_regs[k][i] = 32'd0; m_pend[k][i] = 1'b0; end
      m_busy = 1'b0;
      m_cidx = 0;
    end else if (m_busy) begin
      for (int k = 0; k < 2; k++) m_regs[k][m_cidx] = 32'd0;
      m_cidx = m_cidx + 1;
      if (m_cidx == 32) begin m_busy = 1'b0; m_cidx = 0; end
    end else if (clr_start) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
      m_busy = 1'b1;
      m_cidx = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en && !m_zero(k, result_addr)) begin
          m_regs[k][result_addr] = din;
          m_pend[k][result_addr] = 1'b0;
        end
        if (pend_set && !m_zero(k, pend_addr)) m_pend[k][pend_addr] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_op_one_z", op_one_a, m_read(0, op_one_addr));
    check("cmp_op_two_z", op_two_a, m_read(0, op_two_addr));
    check("cmp_pend_one_z", {31'd0, pend_one_a}, {31'd0, m_pend[0][op_one_addr]});
    check("cmp_pend_two_z", {31'd0, pend_two_a}, {31'd0, m_pend[0][op_two_addr]});
    check("cmp_busy_z", {31'd0, busy_a}, {31'd0, m_busy});
    check("cmp_op_one_nz", op_one_b, m_read(1, op_one_addr));
    check("cmp_op_two_nz", op_two_b, m_read(1, op_two_addr));
    check("cmp_pend_one_nz", {31'd0, pend_one_b}, {31'd0, m_pend[1][op_one_addr]});
    check("cmp_pend_two_nz", {31'd0, pend_two_b}, {31'd0, m_pend[1][op_two_addr]});
    check("cmp_busy_nz", {31'd0, busy_b}, {31'd0, m_busy});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      op_one_addr = i[4:0];
      op_two_addr = 5'(31 - i);
      #1;
      check({name, "_rd1"}, op_one_a | op_one_b, 32'd0);
      check({name, "_rd2"}, op_two_a | op_two_b, 32'd0);
      check({name, "_pend"}, {30'd0, pend_one_a | pend_one_b, pend_two_a | pend_two_b}, 32'd0);
    end
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; result_addr = i[4:0]; din = 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; wr_en = 1'b0; result_addr = 5'd0; din = 32'd0;
    op_one_addr = 5'd0; op_two_addr = 5'd0; pend_set = 1'b0; pend_addr = 5'd0;
    clr_start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_outputs", {op_one_a, 1'b0} | {op_two_a, pend_one_a} | {31'd0, pend_two_a | busy_a}, 33'd0);

    // Write with bypass
    wr_en = 1'b1; result_addr = 5'd5; din = 32'hDEADBEEF; op_one_addr = 5'd5; op_two_addr = 5'd6;
    #1;
    check("bypass_same_cycle", op_one_a, 32'hDEADBEEF);
    check("bypass_other_port", op_two_a, 32'd0);
    tick(); wr_en = 1'b0; #1;
    check("write_persist", op_one_a, 32'hDEADBEEF);

    // Register 0 behaviour in both flavours
    wr_en = 1'b1; result_addr = 5'd0; din = 32'h1234; pend_set = 1'b1; pend_addr = 5'd0;
    op_one_addr = 5'd0; #1;
    check("zero_same_cycle", op_one_a, 32'd0);
    check("nonzero_bypass_r0", op_one_b, 32'h1234);
    tick(); wr_en = 1'b0; pend_set = 1'b0; #1;
    check("zero_next_cycle", op_one_a, 32'd0);
    check("zero_pend", {31'd0, pend_one_a}, 32'd0);
    check("nonzero_r0_data", op_one_b, 32'h1234);
    check("nonzero_r0_pend_set_wins", {31'd0, pend_one_b}, 32'd1);

    // Scoreboard on r7
    pend_set = 1'b1; pend_addr = 5'd7; op_one_addr = 5'd7;
    tick(); pend_set = 1'b0; #1;
    check("pend_set_r7", {31'd0, pend_one_a}, 32'd1);
    pend_set = 1'b1; wr_en = 1'b1; result_addr = 5'd7; din = 32'h77;
    tick(); pend_set = 1'b0; wr_en = 1'b0; #1;
    check("pend_set_wins", {31'd0, pend_one_a}, 32'd1);
    check("pend_set_wins_data", op_one_a, 32'h77);
    wr_en = 1'b1; din = 32'hABCD; #1;
    check("pend_no_bypass", {31'd0, pend_one_a}, 32'd1);
    tick(); wr_en = 1'b0; #1;
    check("pend_cleared_by_write", {31'd0, pend_one_a}, 32'd0);
    check("pend_write_data", op_one_a, 32'hABCD);

    // Asynchronous reset between edges
    op_one_addr = 5'd5; op_two_addr = 5'd7;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("async_rst_op_one", op_one_a, 32'd0);
    check("async_rst_op_two", op_two_a, 32'd0);
    check("async_rst_r0_nz", op_one_b | op_two_b, 32'd0);
    check_all_zero("async_rst");
    @(posedge clk); #3; rst = 1'b0;
    tick();

    // Full clear sequence
    fill();
    pend_set = 1'b1; pend_addr = 5'd9; tick(); pend_set = 1'b0;
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      if (n == 10) begin
        wr_en = 1'b1; result_addr = 5'd3; din = 32'hFFFF; op_one_addr = 5'd3; op_two_addr = 5'd20;
        #1;
        check("clear_no_bypass", op_one_a, 32'd0);
        check("clear_unreached_kept", op_two_a, 32'd20);
      end else begin
        wr_en = 1'b0;
      end
      n++;
      tick();
    end
    wr_en = 1'b0;
    check("clear_busy_cycles", 32'(n), 32'd32);
    check_all_zero("after_clear");

    // Back-to-back clears with clr_start held
    clr_start = 1'b1; tick();
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin n++; tick(); end
    check("b2b_first_len", 32'(n), 32'd32);
    tick();
    check("b2b_restart", {31'd0, busy_a}, 32'd1);
    clr_start = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin n++; tick(); end
    check("b2b_second_len", 32'(n), 32'd32);

    // Reset in the middle of a clear
    fill();
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    repeat (9) tick();
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("mid_clear_rst_busy", {31'd0, busy_a | busy_b}, 32'd0);
    check_all_zero("mid_clear_rst");
    @(posedge clk); #3; rst = 1'b0;
    tick();
    wr_en = 1'b1; result_addr = 5'd4; din = 32'h4444; op_one_addr = 5'd4;
    tick(); wr_en = 1'b0; #1;
    check("write_after_rst", op_one_a, 32'h4444);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
